// File: rtl/wb_align_pkg.sv
// Shared types and lane-mask helper for the Wishbone byte-lane aligner.
package wb_align_pkg;

   localparam int unsigned MAX_NB = 8;
   localparam int unsigned MASK_W = 2 * MAX_NB;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Byte-enable mask of an access, shifted by its lane offset across two beats.
   function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [2:0] off,
                                                   input int unsigned nb);
      logic [MASK_W-1:0] m;
      logic [4:0]        bytes;
      bytes = 5'd1 << size;
      m     = (MASK_W'(1) << bytes) - MASK_W'(1);
      m     = m << off;
      return m & ((MASK_W'(1) << (2 * nb)) - MASK_W'(1));
   endfunction

endpackage

// File: rtl/wb_lane_shifter.sv
// Combinational lane datapath: store data placement across two beats and
// load data extraction with sign/zero extension.
module wb_lane_shifter #(
   parameter int unsigned XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] st_off_i,
   input  logic [1:0]                st_size_i,
   input  logic [XLEN-1:0]           st_wdata_i,
   output logic [XLEN-1:0]           st_lo_o,
   output logic [XLEN-1:0]           st_hi_o,
   input  logic [$clog2(XLEN/8)-1:0] ld_off_i,
   input  logic [1:0]                ld_size_i,
   input  logic                      ld_unsigned_i,
   input  logic [XLEN-1:0]           ld_lo_i,
   input  logic [XLEN-1:0]           ld_hi_i,
   output logic [XLEN-1:0]           ld_data_o
);

   localparam int unsigned IW = $clog2(XLEN);

   logic [XLEN-1:0]   st_trunc;
   logic [2*XLEN-1:0] st_wide;
   logic [XLEN-1:0]   ld_shr;
   logic [IW-1:0]     ld_sidx;
   logic              ld_fill;
   int unsigned       st_bits;
   int unsigned       ld_bits;

   // Access width in bits, clipped to XLEN.
   function automatic int unsigned size_bits(input logic [1:0] size);
      return ((32'd8 << size) > XLEN) ? XLEN : (32'd8 << size);
   endfunction

   always_comb begin
      st_bits  = size_bits(st_size_i);
      st_trunc = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         st_trunc[i] = (i < st_bits) ? st_wdata_i[i] : 1'b0;
      end
      st_wide = {{XLEN{1'b0}}, st_trunc} << {st_off_i, 3'b000};
      st_lo_o = st_wide[XLEN-1:0];
      st_hi_o = st_wide[2*XLEN-1:XLEN];
   end

   always_comb begin
      ld_bits   = size_bits(ld_size_i);
      ld_shr    = XLEN'({ld_hi_i, ld_lo_i} >> {ld_off_i, 3'b000});
      ld_sidx   = IW'(ld_bits - 32'd1);
      ld_fill   = ~ld_unsigned_i & ld_shr[ld_sidx];
      ld_data_o = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         ld_data_o[i] = (i < ld_bits) ? ld_shr[i] : ld_fill;
      end
   end

endmodule

// File: rtl/wb_lane_aligner.sv
// Load/store unit to Wishbone classic aligner: splits lane-crossing accesses
// into two beats and returns extended load data over a valid/ready handshake.
module wb_lane_aligner #(
   parameter int unsigned XLEN             = 32,
   parameter int unsigned SPLIT_MISALIGNED = 1,
   parameter int unsigned TIMEOUT          = 0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [XLEN-1:0]     req_addr_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_unsigned_i,
   input  logic [XLEN-1:0]     req_wdata_i,
   output logic                rsp_valid_o,
   output logic                rsp_err_o,
   output logic [XLEN-1:0]     rsp_rdata_o,
   output logic                cyc_o,
   output logic                stb_o,
   output logic                we_o,
   output logic [XLEN-1:0]     adr_o,
   output logic [XLEN/8-1:0]   sel_o,
   output logic [XLEN-1:0]     dat_o,
   input  logic [XLEN-1:0]     dat_i,
   input  logic                ack_i,
   input  logic                err_i
);

   import wb_align_pkg::*;

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned MW = 2 * NB;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [OW-1:0]     off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              we_q, we_d;
   logic [NB-1:0]     sel1_q, sel1_d;
   logic [XLEN-1:0]   dat1_q, dat1_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [CW-1:0]     tmo_q, tmo_d;
   logic              ready_q, ready_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic [XLEN-1:0]   adr_q, adr_d;
   logic [NB-1:0]     sel_q, sel_d;
   logic [XLEN-1:0]   dat_q, dat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [OW-1:0]     req_off;
   logic [MW-1:0]     req_mask;
   logic [NB-1:0]     req_sel0;
   logic [NB-1:0]     req_sel1;
   logic              imm_err;
   logic              bus_ack;
   logic              bus_err;
   logic              tmo_hit;
   logic [XLEN-1:0]   st_lo;
   logic [XLEN-1:0]   st_hi;
   logic [XLEN-1:0]   ld_lo;
   logic [XLEN-1:0]   ld_hi;
   logic [XLEN-1:0]   ld_data;

   assign req_off  = req_addr_i[OW-1:0];
   assign req_mask = MW'(lane_mask(req_size_i, 3'(req_off), NB));
   assign req_sel0 = req_mask[NB-1:0];
   assign req_sel1 = req_mask[MW-1:NB];
   assign imm_err  = ((XLEN == 32) && (size_e'(req_size_i) == DWORD)) ||
                     ((SPLIT_MISALIGNED == 0) && (req_sel1 != '0));

   // Terminations only count while a strobe is out; err beats ack.
   assign bus_err  = stb_q & err_i;
   assign bus_ack  = stb_q & ack_i & ~err_i;
   assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == CW'(TIMEOUT - 1));

   // Beat1 always reads the high half; a single beat uses a zero high half.
   assign ld_lo = (state_q == BEAT1) ? lo_q  : dat_i;
   assign ld_hi = (state_q == BEAT1) ? dat_i : '0;

   wb_lane_shifter #(.XLEN(XLEN)) u_shifter (
      .st_off_i      (req_off),
      .st_size_i     (req_size_i),
      .st_wdata_i    (req_wdata_i),
      .st_lo_o       (st_lo),
      .st_hi_o       (st_hi),
      .ld_off_i      (off_q),
      .ld_size_i     (size_q),
      .ld_unsigned_i (uns_q),
      .ld_lo_i       (ld_lo),
      .ld_hi_i       (ld_hi),
      .ld_data_o     (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      size_d      = size_q;
      uns_d       = uns_q;
      we_d        = we_q;
      sel1_d      = sel1_q;
      dat1_d      = dat1_q;
      lo_d        = lo_q;
      tmo_d       = tmo_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      adr_d       = adr_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               off_d  = req_off;
               size_d = req_size_i;
               uns_d  = req_unsigned_i;
               if (imm_err) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = BEAT0;
                  we_d    = req_we_i;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  adr_d   = {req_addr_i[XLEN-1:OW], {OW{1'b0}}};
                  sel_d   = req_sel0;
                  dat_d   = req_we_i ? st_lo : '0;
                  sel1_d  = req_sel1;
                  dat1_d  = req_we_i ? st_hi : '0;
                  tmo_d   = '0;
               end
            end
         end
         BEAT0, BEAT1: begin
            tmo_d = tmo_q + CW'(1);
            if (bus_err || tmo_hit ||
                (bus_ack && ((state_q == BEAT1) || (sel1_q == '0)))) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               adr_d       = '0;
               sel_d       = '0;
               dat_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ~bus_ack;
               rsp_rdata_d = (bus_ack && !we_q) ? ld_data : '0;
            end else if (bus_ack) begin
               state_d = BEAT1;
               adr_d   = adr_q + XLEN'(NB);
               sel_d   = sel1_q;
               dat_d   = dat1_q;
               lo_d    = dat_i;
               tmo_d   = '0;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         off_q       <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         we_q        <= 1'b0;
         sel1_q      <= '0;
         dat1_q      <= '0;
         lo_q        <= '0;
         tmo_q       <= '0;
         ready_q     <= 1'b1;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         we_q        <= we_d;
         sel1_q      <= sel1_d;
         dat1_q      <= dat1_d;
         lo_q        <= lo_d;
         tmo_q       <= tmo_d;
         ready_q     <= ready_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         adr_q       <= adr_d;
         sel_q       <= sel_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = stb_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign sel_o       = sel_q;
   assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_lane_aligner.sv
// Scoreboard bench for wb_lane_aligner: a 32-bit split/timeout instance with a
// queued slave and response monitor, plus no-split and 64-bit instances.
module tb_wb_lane_aligner;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
      logic [1:0]  term;   // bit0 ack, bit1 err
      logic [31:0] rd;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cnt = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   orphan = 0;
   int   rsp_seen = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   rsp_t  exp_q[$];
   beat_t beat_q[$];
   rsp_t  e;
   beat_t b;

   // DUT A: 32-bit, split enabled, timeout 4
   logic        a_valid = 0, a_ready, a_we = 0, a_uns = 0;
   logic [31:0] a_addr = 0, a_wdata = 0;
   logic [1:0]  a_size = 0;
   logic        a_rsp_valid, a_rsp_err, a_cyc, a_stb, a_we_o;
   logic [31:0] a_rdata, a_adr, a_dat_o, a_dat_in = 0;
   logic [3:0]  a_sel;
   logic        a_ack = 0, a_err_in = 0;

   wb_lane_aligner #(.XLEN(32), .SPLIT_MISALIGNED(1), .TIMEOUT(4)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
      .req_addr_i(a_addr), .req_size_i(a_size), .req_unsigned_i(a_uns),
      .req_wdata_i(a_wdata), .rsp_valid_o(a_rsp_valid), .rsp_err_o(a_rsp_err),
      .rsp_rdata_o(a_rdata), .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we_o),
      .adr_o(a_adr), .sel_o(a_sel), .dat_o(a_dat_o), .dat_i(a_dat_in),
      .ack_i(a_ack), .err_i(a_err_in));

   // DUT B: 32-bit, misaligned accesses rejected
   logic        b_valid = 0, b_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we_o;
   logic [31:0] b_addr = 0, b_rdata, b_adr, b_dat_o;
   logic [1:0]  b_size = 0;
   logic [3:0]  b_sel;

   wb_lane_aligner #(.XLEN(32), .SPLIT_MISALIGNED(0), .TIMEOUT(0)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(1'b0),
      .req_addr_i(b_addr), .req_size_i(b_size), .req_unsigned_i(1'b0),
      .req_wdata_i(32'h0), .rsp_valid_o(b_rsp_valid), .rsp_err_o(b_rsp_err),
      .rsp_rdata_o(b_rdata), .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we_o),
      .adr_o(b_adr), .sel_o(b_sel), .dat_o(b_dat_o), .dat_i(32'h0),
      .ack_i(1'b0), .err_i(1'b0));

   // DUT C: 64-bit
   logic        c_valid = 0, c_ready, c_rsp_valid, c_rsp_err, c_cyc, c_stb, c_we_o;
   logic [63:0] c_addr = 0, c_rdata, c_adr, c_dat_o, c_dat_in = 0;
   logic [1:0]  c_size = 0;
   logic [7:0]  c_sel;
   logic        c_ack = 0;

   wb_lane_aligner #(.XLEN(64), .SPLIT_MISALIGNED(1), .TIMEOUT(0)) dut_c (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(c_valid), .req_ready_o(c_ready), .req_we_i(1'b0),
      .req_addr_i(c_addr), .req_size_i(c_size), .req_unsigned_i(1'b0),
      .req_wdata_i(64'h0), .rsp_valid_o(c_rsp_valid), .rsp_err_o(c_rsp_err),
      .rsp_rdata_o(c_rdata), .cyc_o(c_cyc), .stb_o(c_stb), .we_o(c_we_o),
      .adr_o(c_adr), .sel_o(c_sel), .dat_o(c_dat_o), .dat_i(c_dat_in),
      .ack_i(c_ack), .err_i(1'b0));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Slave for DUT A: checks each strobed beat and terminates it from the queue.
   always @(negedge clk) begin
      a_ack    = 1'b0;
      a_err_in = 1'b0;
      a_dat_in = '0;
      if (a_stb) begin
         if (beat_q.size() == 0) begin
            orphan++;
         end else begin
            b = beat_q.pop_front();
            chk("beat_cyc", 64'(a_cyc), 64'(1'b1));
            chk("beat_adr", 64'(a_adr), 64'(b.adr));
            chk("beat_sel", 64'(a_sel), 64'(b.sel));
            chk("beat_dat", 64'(a_dat_o), 64'(b.dat));
            chk("beat_we",  64'(a_we_o), 64'(b.we));
            a_dat_in = b.rd;
            a_ack    = b.term[0];
            a_err_in = b.term[1];
         end
      end
   end

   // Response monitor for DUT A.
   always @(negedge clk) begin
      if (a_rsp_valid) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
         end else begin
            e = exp_q.pop_front();
            chk("rsp_err",   64'(a_rsp_err), 64'(e.err));
            chk("rsp_rdata", 64'(a_rdata), 64'(e.rdata));
            chk("rsp_cycle", 64'(cnt), 64'(e.cyc));
         end
      end
   end

   task automatic send_a(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         input logic eerr, input logic [31:0] erd, input int lat);
      int n = 0;
      @(negedge clk);
      while (!a_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      a_valid = 1'b1; a_we = we; a_addr = addr; a_size = size; a_uns = uns; a_wdata = wdata;
      exp_q.push_back('{err: eerr, rdata: erd, cyc: cnt + lat});
      @(posedge clk);
      #1 a_valid = 1'b0;
   endtask

   task automatic wait_a();
      int n = 0;
      while ((exp_q.size() != 0 || beat_q.size() != 0 || !a_ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_a: got %0d responses pending required 0", exp_q.size());
         exp_q.delete();
         beat_q.delete();
      end
   endtask

   initial begin
      int t0;
      int seen0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(a_ready), 64'(1'b1));
      chk("rst_cyc",   64'({a_cyc, a_stb, a_we_o}), 64'(0));
      chk("rst_rsp",   64'({a_rsp_valid, a_rsp_err}), 64'(0));
      chk("rst_bus",   64'({a_adr, a_sel}), 64'(0));
      chk("rst_rdata", 64'(a_rdata), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);

      // Aligned word load
      beat_q.push_back('{32'h100, 4'b1111, 32'h0, 1'b0, 2'b01, 32'hDEADBEEF});
      send_a(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 2);
      wait_a();

      // Signed and unsigned byte load in the top lane
      beat_q.push_back('{32'h100, 4'b1000, 32'h0, 1'b0, 2'b01, 32'h80FFFFFF});
      send_a(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 2);
      wait_a();
      beat_q.push_back('{32'h100, 4'b1000, 32'h0, 1'b0, 2'b01, 32'h80FFFFFF});
      send_a(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 1'b0, 32'h00000080, 2);
      wait_a();

      // Signed halfword load in the upper half
      beat_q.push_back('{32'h104, 4'b1100, 32'h0, 1'b0, 2'b01, 32'h80015A5A});
      send_a(1'b0, 32'h106, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF8001, 2);
      wait_a();

      // Split halfword store
      beat_q.push_back('{32'h0FC, 4'b1000, 32'hCD000000, 1'b1, 2'b01, 32'h0});
      beat_q.push_back('{32'h100, 4'b0001, 32'h000000AB, 1'b1, 2'b01, 32'h0});
      send_a(1'b1, 32'h0FF, 2'd1, 1'b0, 32'h0000ABCD, 1'b0, 32'h0, 3);
      wait_a();

      // Aligned halfword store
      beat_q.push_back('{32'h200, 4'b1100, 32'h12340000, 1'b1, 2'b01, 32'h0});
      send_a(1'b1, 32'h202, 2'd1, 1'b0, 32'h00001234, 1'b0, 32'h0, 2);
      wait_a();

      // Split word load assembling lanes from both beats
      beat_q.push_back('{32'h0FC, 4'b1100, 32'h0, 1'b0, 2'b01, 32'h22119999});
      beat_q.push_back('{32'h100, 4'b0011, 32'h0, 1'b0, 2'b01, 32'h88884433});
      send_a(1'b0, 32'h0FE, 2'd2, 1'b0, 32'h0, 1'b0, 32'h44332211, 3);
      wait_a();

      // Err on beat0 of a split load suppresses beat1
      @(posedge clk) orphan = 0;
      beat_q.push_back('{32'h0FC, 4'b1100, 32'h0, 1'b0, 2'b10, 32'h0});
      send_a(1'b0, 32'h0FE, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 2);
      wait_a();
      repeat (2) @(negedge clk);
      chk("err_no_beat1", 64'(orphan), 64'(0));

      // Simultaneous ack and err: err wins
      beat_q.push_back('{32'h300, 4'b1111, 32'h0, 1'b0, 2'b11, 32'h12345678});
      send_a(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 2);
      wait_a();

      // Dword on a 32-bit instance is an immediate error with no bus cycle
      @(posedge clk) orphan = 0;
      send_a(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1);
      wait_a();
      chk("dword32_no_bus", 64'(orphan), 64'(0));

      // Timeout after four unanswered strobe cycles
      @(posedge clk) orphan = 0;
      send_a(1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 5);
      wait_a();
      chk("timeout_stb_cycles", 64'(orphan), 64'(4));

      // Reset mid-beat drops the bus and yields no response
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h500; a_size = 2'd2;
      @(posedge clk);
      #1 a_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_cyc", 64'(a_cyc), 64'(1'b1));
      seen0 = rsp_seen;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_cyc", 64'({a_cyc, a_stb}), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_no_rsp", 64'(rsp_seen), 64'(seen0));
      chk("rst_mid_ready", 64'(a_ready), 64'(1'b1));

      // No-split instance rejects a misaligned word immediately
      @(negedge clk);
      b_valid = 1'b1; b_addr = 32'h102; b_size = 2'd2;
      @(posedge clk);
      #1 b_valid = 1'b0;
      @(negedge clk);
      chk("nosplit_rsp", 64'({b_rsp_valid, b_rsp_err}), 64'(2'b11));
      chk("nosplit_cyc", 64'({b_cyc, b_stb}), 64'(0));
      @(negedge clk);
      chk("nosplit_pulse", 64'(b_rsp_valid), 64'(1'b0));
      chk("nosplit_ready", 64'(b_ready), 64'(1'b1));

      // 64-bit dword load wrapping at the top of the address space
      @(negedge clk);
      c_valid = 1'b1; c_addr = 64'hFFFF_FFFF_FFFF_FFFC; c_size = 2'd3;
      t0 = cnt;
      @(posedge clk);
      #1 c_valid = 1'b0;
      @(negedge clk);
      chk("x64_b0_stb", 64'(c_stb), 64'(1'b1));
      chk("x64_b0_adr", c_adr, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("x64_b0_sel", 64'(c_sel), 64'(8'hF0));
      c_ack = 1'b1; c_dat_in = 64'h44332211_AAAAAAAA;
      @(negedge clk);
      chk("x64_b1_stb", 64'(c_stb), 64'(1'b1));
      chk("x64_b1_adr", c_adr, 64'h0);
      chk("x64_b1_sel", 64'(c_sel), 64'(8'h0F));
      c_dat_in = 64'hBBBBBBBB_88776655;
      @(negedge clk);
      c_ack = 1'b0; c_dat_in = '0;
      chk("x64_rsp", 64'({c_rsp_valid, c_rsp_err, c_cyc}), 64'(3'b100));
      chk("x64_rdata", c_rdata, 64'h88776655_44332211);
      chk("x64_cycle", 64'(cnt - t0), 64'(3));

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
